// File: rtl/time_entry_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_entry_counter_pkg
// Description : Shared state encoding and BCD constants for the MM:SS timer.
// Revision    : 1.0 - initial release
// ============================================================================
package time_entry_counter_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;
    localparam int MAX_MINUTES  = 99;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/time_entry_counter_bcd_mmss_decrement.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mmss_decrement
// Description : Combinational one-second decrement of a BCD MM:SS value with
//               borrow chain, plus a flag for a zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mmss_decrement
    import time_entry_counter_pkg::*;
(
    input  logic [BCD_W-1:0] sec_unit,
    input  logic [BCD_W-1:0] sec_tens,
    input  logic [BCD_W-1:0] min_unit,
    input  logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] dec_sec_unit,
    output logic [BCD_W-1:0] dec_sec_tens,
    output logic [BCD_W-1:0] dec_min_unit,
    output logic [BCD_W-1:0] dec_min_tens,
    output logic             dec_zero
);

    logic w_borrow_su;
    logic w_borrow_st;
    logic w_borrow_mu;

    assign w_borrow_su = (sec_unit == '0);
    assign w_borrow_st = w_borrow_su && (sec_tens == '0);
    assign w_borrow_mu = w_borrow_st && (min_unit == '0);

    assign dec_sec_unit = w_borrow_su ? bcd_t'(DIGIT_MAX) : sec_unit - 4'd1;

    always_comb begin
        dec_sec_tens = sec_tens;
        dec_min_unit = min_unit;
        dec_min_tens = min_tens;
        if (w_borrow_su) begin
            dec_sec_tens = (sec_tens == '0) ? bcd_t'(SEC_TENS_MAX) : sec_tens - 4'd1;
        end
        if (w_borrow_st) begin
            dec_min_unit = (min_unit == '0) ? bcd_t'(DIGIT_MAX) : min_unit - 4'd1;
        end
        if (w_borrow_mu) begin
            dec_min_tens = (min_tens == '0) ? bcd_t'(DIGIT_MAX) : min_tens - 4'd1;
        end
    end

    assign dec_zero = (dec_sec_unit == '0) && (dec_sec_tens == '0) &&
                      (dec_min_unit == '0) && (dec_min_tens == '0);

endmodule
`default_nettype wire

// File: rtl/time_entry_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_entry_counter
// Description : Keypad MM:SS preset entry, seconds normalisation and 1 Hz
//               countdown with completion flag for the microwave controller.
// Revision    : 1.0 - initial release
// ============================================================================
module time_entry_counter
    import time_entry_counter_pkg::*;
#(
    parameter int MAX_DIGITS        = 4,
    parameter int TICK_DURING_ENTRY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] digit,
    input  logic             tick_1hz,
    input  logic             run,
    input  logic             clear_req,
    output logic [BCD_W-1:0] out_second_unit,
    output logic [BCD_W-1:0] out_second_tens,
    output logic [BCD_W-1:0] out_minute_unit,
    output logic [BCD_W-1:0] out_minute_tens,
    output logic [2:0]       entry_count,
    output logic             digit_err,
    output logic             finished
);

    localparam bit c_tick_on_entry = (TICK_DURING_ENTRY != 0);

    state_t     r_state, w_state_nxt;
    bcd_t       r_sec_unit, r_sec_tens, r_min_unit, r_min_tens;
    bcd_t       w_sec_unit_nxt, w_sec_tens_nxt, w_min_unit_nxt, w_min_tens_nxt;
    logic [2:0] r_entry_count, w_entry_count_nxt;
    logic       r_digit_err, w_digit_err_nxt;
    logic       r_finished, w_finished_nxt;

    bcd_t w_norm_sec_unit, w_norm_sec_tens, w_norm_min_unit, w_norm_min_tens;
    bcd_t w_dec_in_su, w_dec_in_st, w_dec_in_mu, w_dec_in_mt;
    bcd_t w_dec_su, w_dec_st, w_dec_mu, w_dec_mt;
    logic w_dec_zero;
    logic w_cur_zero;
    logic w_min_at_max;
    logic w_digit_ok;
    logic w_has_room;
    logic w_load_taken;

    assign w_cur_zero   = (r_sec_unit == '0) && (r_sec_tens == '0) &&
                          (r_min_unit == '0) && (r_min_tens == '0);
    assign w_min_at_max = (r_min_tens == bcd_t'(MAX_MINUTES / 10)) &&
                          (r_min_unit == bcd_t'(MAX_MINUTES % 10));
    assign w_digit_ok   = (digit <= bcd_t'(DIGIT_MAX));
    assign w_has_room   = (r_entry_count < 3'(MAX_DIGITS));

    // Seconds tens above 5 means S >= 60: drop 60 and carry one minute.
    always_comb begin
        w_norm_sec_unit = r_sec_unit;
        w_norm_sec_tens = r_sec_tens;
        w_norm_min_unit = r_min_unit;
        w_norm_min_tens = r_min_tens;
        if (r_sec_tens > bcd_t'(SEC_TENS_MAX)) begin
            w_norm_sec_tens = r_sec_tens - bcd_t'(SEC_TENS_MAX + 1);
            if (w_min_at_max) begin
                w_norm_min_tens = bcd_t'(MAX_MINUTES / 10);
                w_norm_min_unit = bcd_t'(MAX_MINUTES % 10);
                w_norm_sec_tens = bcd_t'(SEC_TENS_MAX);
                w_norm_sec_unit = bcd_t'(DIGIT_MAX);
            end else if (r_min_unit == bcd_t'(DIGIT_MAX)) begin
                w_norm_min_unit = '0;
                w_norm_min_tens = r_min_tens + 4'd1;
            end else begin
                w_norm_min_unit = r_min_unit + 4'd1;
            end
        end
    end

    // On the entry transition the decrementer sees the normalised value.
    assign w_dec_in_su = (r_state == ENTRY) ? w_norm_sec_unit : r_sec_unit;
    assign w_dec_in_st = (r_state == ENTRY) ? w_norm_sec_tens : r_sec_tens;
    assign w_dec_in_mu = (r_state == ENTRY) ? w_norm_min_unit : r_min_unit;
    assign w_dec_in_mt = (r_state == ENTRY) ? w_norm_min_tens : r_min_tens;

    bcd_mmss_decrement u_dec (
        .sec_unit     (w_dec_in_su),
        .sec_tens     (w_dec_in_st),
        .min_unit     (w_dec_in_mu),
        .min_tens     (w_dec_in_mt),
        .dec_sec_unit (w_dec_su),
        .dec_sec_tens (w_dec_st),
        .dec_min_unit (w_dec_mu),
        .dec_min_tens (w_dec_mt),
        .dec_zero     (w_dec_zero)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_sec_unit_nxt    = r_sec_unit;
        w_sec_tens_nxt    = r_sec_tens;
        w_min_unit_nxt    = r_min_unit;
        w_min_tens_nxt    = r_min_tens;
        w_entry_count_nxt = r_entry_count;
        w_digit_err_nxt   = 1'b0;
        w_finished_nxt    = r_finished;
        w_load_taken      = 1'b0;

        if (clear_req) begin
            w_state_nxt       = IDLE;
            w_sec_unit_nxt    = '0;
            w_sec_tens_nxt    = '0;
            w_min_unit_nxt    = '0;
            w_min_tens_nxt    = '0;
            w_entry_count_nxt = '0;
            w_finished_nxt    = 1'b0;
        end else begin
            if (load) begin
                if ((r_state == IDLE || r_state == ENTRY) && w_digit_ok && w_has_room) begin
                    w_min_tens_nxt    = r_min_unit;
                    w_min_unit_nxt    = r_sec_tens;
                    w_sec_tens_nxt    = r_sec_unit;
                    w_sec_unit_nxt    = digit;
                    w_entry_count_nxt = r_entry_count + 3'd1;
                    w_state_nxt       = ENTRY;
                    w_load_taken      = 1'b1;
                end else if (r_state == DONE && w_digit_ok) begin
                    w_min_tens_nxt    = '0;
                    w_min_unit_nxt    = '0;
                    w_sec_tens_nxt    = '0;
                    w_sec_unit_nxt    = digit;
                    w_entry_count_nxt = 3'd1;
                    w_finished_nxt    = 1'b0;
                    w_state_nxt       = ENTRY;
                    w_load_taken      = 1'b1;
                end else begin
                    w_digit_err_nxt   = 1'b1;
                end
            end

            if (!w_load_taken) begin
                case (r_state)
                    ENTRY: begin
                        if (run && !w_cur_zero) begin
                            w_state_nxt    = RUN;
                            w_sec_unit_nxt = w_norm_sec_unit;
                            w_sec_tens_nxt = w_norm_sec_tens;
                            w_min_unit_nxt = w_norm_min_unit;
                            w_min_tens_nxt = w_norm_min_tens;
                            if (c_tick_on_entry && tick_1hz) begin
                                w_sec_unit_nxt = w_dec_su;
                                w_sec_tens_nxt = w_dec_st;
                                w_min_unit_nxt = w_dec_mu;
                                w_min_tens_nxt = w_dec_mt;
                                if (w_dec_zero) begin
                                    w_state_nxt    = DONE;
                                    w_finished_nxt = 1'b1;
                                end
                            end
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            w_state_nxt = PAUSED;
                        end else if (tick_1hz) begin
                            w_sec_unit_nxt = w_dec_su;
                            w_sec_tens_nxt = w_dec_st;
                            w_min_unit_nxt = w_dec_mu;
                            w_min_tens_nxt = w_dec_mt;
                            if (w_dec_zero) begin
                                w_state_nxt    = DONE;
                                w_finished_nxt = 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (run) begin
                            w_state_nxt = RUN;
                            if (c_tick_on_entry && tick_1hz) begin
                                w_sec_unit_nxt = w_dec_su;
                                w_sec_tens_nxt = w_dec_st;
                                w_min_unit_nxt = w_dec_mu;
                                w_min_tens_nxt = w_dec_mt;
                                if (w_dec_zero) begin
                                    w_state_nxt    = DONE;
                                    w_finished_nxt = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sec_unit    <= '0;
            r_sec_tens    <= '0;
            r_min_unit    <= '0;
            r_min_tens    <= '0;
            r_entry_count <= '0;
            r_digit_err   <= 1'b0;
            r_finished    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sec_unit    <= w_sec_unit_nxt;
            r_sec_tens    <= w_sec_tens_nxt;
            r_min_unit    <= w_min_unit_nxt;
            r_min_tens    <= w_min_tens_nxt;
            r_entry_count <= w_entry_count_nxt;
            r_digit_err   <= w_digit_err_nxt;
            r_finished    <= w_finished_nxt;
        end
    end

    assign out_second_unit = r_sec_unit;
    assign out_second_tens = r_sec_tens;
    assign out_minute_unit = r_min_unit;
    assign out_minute_tens = r_min_tens;
    assign entry_count     = r_entry_count;
    assign digit_err       = r_digit_err;
    assign finished        = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_time_entry_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_entry_counter
// Description : Directed and randomized checks of the MM:SS entry/countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_entry_counter;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic       clk = 1'b0;
    logic       rst, load, tick_1hz, run, clear_req;
    logic [3:0] digit;
    logic [3:0] out_second_unit, out_second_tens, out_minute_unit, out_minute_tens;
    logic [2:0] entry_count;
    logic       digit_err, finished;
    logic [15:0] disp;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: value held as plain minutes/seconds integers.
    int m_state, m_mm, m_ss, m_cnt, m_err, m_fin;

    assign disp = {out_minute_tens, out_minute_unit, out_second_tens, out_second_unit};

    time_entry_counter dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .digit           (digit),
        .tick_1hz        (tick_1hz),
        .run             (run),
        .clear_req       (clear_req),
        .out_second_unit (out_second_unit),
        .out_second_tens (out_second_tens),
        .out_minute_unit (out_minute_unit),
        .out_minute_tens (out_minute_tens),
        .entry_count     (entry_count),
        .digit_err       (digit_err),
        .finished        (finished)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd16(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_mm = 0; m_ss = 0; m_cnt = 0; m_err = 0; m_fin = 0;
    endtask

    task automatic model_update(input bit l, input int d, input bit r, input bit t, input bit c);
        bit taken;
        int n, secs;
        taken = 0;
        m_err = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (l) begin
            if ((m_state == M_IDLE || m_state == M_ENTRY) && d <= 9 && m_cnt < 4) begin
                n = ((m_mm * 100 + m_ss) * 10 + d) % 10000;
                m_mm = n / 100; m_ss = n % 100;
                m_cnt++; m_state = M_ENTRY; taken = 1;
            end else if (m_state == M_DONE && d <= 9) begin
                m_mm = 0; m_ss = d; m_cnt = 1; m_fin = 0; m_state = M_ENTRY; taken = 1;
            end else begin
                m_err = 1;
            end
        end
        if (!taken) begin
            if (m_state == M_ENTRY) begin
                if (r && (m_mm != 0 || m_ss != 0)) begin
                    if (m_ss >= 60) begin m_ss -= 60; m_mm += 1; end
                    if (m_mm > 99) begin m_mm = 99; m_ss = 59; end
                    m_state = M_RUN;
                end
            end else if (m_state == M_RUN) begin
                if (!r) m_state = M_PAUSED;
                else if (t) begin
                    secs = m_mm * 60 + m_ss - 1;
                    m_mm = secs / 60; m_ss = secs % 60;
                    if (secs == 0) begin m_state = M_DONE; m_fin = 1; end
                end
            end else if (m_state == M_PAUSED) begin
                if (r) m_state = M_RUN;
            end
        end
    endtask

    task automatic cycle(input bit l, input logic [3:0] d, input bit r, input bit t, input bit c);
        load = l; digit = d; run = r; tick_1hz = t; clear_req = c;
        @(posedge clk);
        model_update(l, int'(d), r, t, c);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; digit = 0; run = 0; tick_1hz = 0; clear_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (disp !== 16'h0000) $display("FAIL reset_disp got=%h exp=%h", disp, 16'h0000); else n_pass++;
        n_checks++; if (entry_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", entry_count); else n_pass++;
        n_checks++; if ({digit_err, finished} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {digit_err, finished}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_countdown();
        logic [15:0] exp_tbl [4] = '{16'h0129, 16'h0128, 16'h0127, 16'h0126};
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0); cycle(1, 3, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        n_checks++; if (disp !== 16'h0130) $display("FAIL countdown_entry got=%h exp=%h", disp, 16'h0130); else n_pass++;
        cycle(0, 0, 1, 0, 0);
        n_checks++; if (disp !== 16'h0130) $display("FAIL countdown_run got=%h exp=%h", disp, 16'h0130); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 1, 0);
            n_checks++; if (disp !== exp_tbl[i]) $display("FAIL countdown_tick%0d got=%h exp=%h", i, disp, exp_tbl[i]); else n_pass++;
        end
        n_checks++; if (finished !== 1'b0) $display("FAIL countdown_fin got=%b exp=0", finished); else n_pass++;
    endtask

    task automatic test_normalise();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 9, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        n_checks++; if (disp !== 16'h0090) $display("FAIL norm_entry got=%h exp=%h", disp, 16'h0090); else n_pass++;
        cycle(0, 0, 1, 0, 0);
        n_checks++; if (disp !== 16'h0130) $display("FAIL norm_90 got=%h exp=%h", disp, 16'h0130); else n_pass++;
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 9, 0, 0, 0);
        n_checks++; if (entry_count !== 3'd4) $display("FAIL norm_count got=%0d exp=4", entry_count); else n_pass++;
        cycle(0, 0, 1, 0, 0);
        n_checks++; if (disp !== 16'h9959) $display("FAIL norm_clamp got=%h exp=%h", disp, 16'h9959); else n_pass++;
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 1, 0);
        n_checks++; if (disp !== 16'h0959) $display("FAIL borrow_chain got=%h exp=%h", disp, 16'h0959); else n_pass++;
    endtask

    task automatic test_done();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 2, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        n_checks++; if (disp !== 16'h0001) $display("FAIL done_tick1 got=%h exp=%h", disp, 16'h0001); else n_pass++;
        cycle(0, 0, 1, 1, 0);
        n_checks++; if ({disp, finished} !== {16'h0000, 1'b1}) $display("FAIL done_zero got=%h/%b exp=0000/1", disp, finished); else n_pass++;
        cycle(0, 0, 1, 1, 0);
        n_checks++; if ({disp, finished} !== {16'h0000, 1'b1}) $display("FAIL done_hold got=%h/%b exp=0000/1", disp, finished); else n_pass++;
        cycle(1, 5, 0, 0, 0);
        n_checks++; if ({disp, finished, entry_count} !== {16'h0005, 1'b0, 3'd1}) $display("FAIL done_reload got=%h/%b/%0d exp=0005/0/1", disp, finished, entry_count); else n_pass++;
    endtask

    task automatic test_errors();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 4'hA, 0, 0, 0);
        n_checks++; if ({digit_err, disp, entry_count} !== {1'b1, 16'h0003, 3'd1}) $display("FAIL err_bad_digit got=%b/%h/%0d exp=1/0003/1", digit_err, disp, entry_count); else n_pass++;
        cycle(0, 0, 0, 0, 0);
        n_checks++; if (digit_err !== 1'b0) $display("FAIL err_pulse_width got=%b exp=0", digit_err); else n_pass++;
        cycle(1, 1, 0, 0, 0); cycle(1, 2, 0, 0, 0); cycle(1, 3, 0, 0, 0);
        cycle(1, 4, 0, 0, 0);
        n_checks++; if ({digit_err, disp, entry_count} !== {1'b1, 16'h3123, 3'd4}) $display("FAIL err_fifth got=%b/%h/%0d exp=1/3123/4", digit_err, disp, entry_count); else n_pass++;
    endtask

    task automatic test_pause();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 4, 0, 0, 0); cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            n_checks++; if (disp !== 16'h0045) $display("FAIL pause_hold%0d got=%h exp=%h", i, disp, 16'h0045); else n_pass++;
        end
        cycle(1, 7, 0, 0, 0);
        n_checks++; if ({digit_err, disp} !== {1'b1, 16'h0045}) $display("FAIL pause_load got=%b/%h exp=1/0045", digit_err, disp); else n_pass++;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        n_checks++; if (disp !== 16'h0044) $display("FAIL pause_resume got=%h exp=%h", disp, 16'h0044); else n_pass++;
    endtask

    task automatic test_async_reset_clear();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({disp, entry_count, finished} !== {16'h0000, 3'd0, 1'b0}) $display("FAIL async_reset got=%h/%0d/%b exp=0000/0/0", disp, entry_count, finished); else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1, 2, 0, 0, 0); cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        n_checks++; if ({disp, entry_count, finished} !== {16'h0000, 3'd0, 1'b0}) $display("FAIL clear_paused got=%h/%0d/%b exp=0000/0/0", disp, entry_count, finished); else n_pass++;
    endtask

    task automatic test_random();
        bit r_lvl;
        bit l, c, t;
        logic [3:0] d;
        r_lvl = 0;
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) r_lvl = ~r_lvl;
            l = ($urandom_range(0, 9) < 2);
            d = 4'($urandom_range(0, 11));
            t = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 99) < 2);
            cycle(l, d, r_lvl, t, c);
            n_checks++; if (disp !== bcd16(m_mm, m_ss)) $display("FAIL rand_disp cyc=%0d got=%h exp=%h", i, disp, bcd16(m_mm, m_ss)); else n_pass++;
            n_checks++; if (entry_count !== 3'(m_cnt)) $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, entry_count, m_cnt); else n_pass++;
            n_checks++; if (digit_err !== 1'(m_err)) $display("FAIL rand_err cyc=%0d got=%b exp=%0d", i, digit_err, m_err); else n_pass++;
            n_checks++; if (finished !== 1'(m_fin)) $display("FAIL rand_fin cyc=%0d got=%b exp=%0d", i, finished, m_fin); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_normalise();
        test_done();
        test_errors();
        test_pause();
        test_async_reset_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
